// File: rtl/my_mux_pkg.sv
// my_mux_pkg: shared sizes, FSM encoding and select type for the 8-way round-robin collector
package my_mux_pkg;
   localparam int N_WAYS = 8;
   localparam int SEL_W  = 3;
   typedef enum logic {EMPTY, FULL} state_t;
   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/my_rr_arbiter_8.sv
// my_rr_arbiter_8: combinational round-robin find-first starting at ptr (rotate, priority, rotate back)
module my_rr_arbiter_8
   import my_mux_pkg::*;
(
   input  logic [N_WAYS-1:0] req,
   input  sel_t              ptr,
   input  logic              en,
   output logic [N_WAYS-1:0] gnt,
   output sel_t              gnt_idx,
   output logic              any
);
   logic [2*N_WAYS-1:0] dbl;
   logic [N_WAYS-1:0]   rot;
   sel_t                first;
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[N_WAYS-1:0];
      first = '0;
      for (int i = N_WAYS-1; i >= 0; i--)
         if (rot[i]) first = sel_t'(i);
      any = |req;
      gnt_idx = first + ptr;
      gnt = (en && any) ? ({{(N_WAYS-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   end
endmodule

// File: rtl/my_mux_8_way_rr.sv
// my_mux_8_way_rr: 8-to-1 round-robin collector onto one registered, source-tagged output stream
module my_mux_8_way_rr
   import my_mux_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_WAYS-1:0]       in_valid,
   input  logic [N_WAYS*WIDTH-1:0] in_data,
   output logic [N_WAYS-1:0]       in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output sel_t                    out_sel
);
   state_t state, state_nx;
   sel_t   ptr, gnt_idx;
   logic   ld, any;
   always_comb ld = (state == EMPTY) || out_ready;
   // rst_n gates the enable so in_ready stays low while reset is held
   my_rr_arbiter_8 u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .en      (ld && rst_n),
      .gnt     (in_ready),
      .gnt_idx (gnt_idx),
      .any     (any)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   always_comb state_nx = ld ? (any ? FULL : EMPTY) : state;
   always_comb out_valid = (state == FULL);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_data <= '0;
         out_sel  <= '0;
         ptr      <= '0;
      end else if (ld && any) begin
         out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
         out_sel  <= gnt_idx;
         ptr      <= gnt_idx + 3'd1;
      end
endmodule

// File: tb/tb_my_mux_8_way_rr.sv
// tb_my_mux_8_way_rr: directed self-checking bench for the round-robin collector
module tb_my_mux_8_way_rr;
   localparam int W = 16;
   logic            clk = 0;
   logic            rst_n;
   logic [7:0]      in_valid;
   logic [8*W-1:0]  in_data;
   logic [7:0]      in_ready;
   logic            out_valid, out_ready;
   logic [W-1:0]    out_data;
   logic [2:0]      out_sel;
   logic [W-1:0]    dmux [8];
   int total = 0, fails = 0;

   my_mux_8_way_rr #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel));

   always #5 clk = ~clk;

   // reference demultiplexer fanning the tagged stream back out by out_sel
   always_comb
      for (int k = 0; k < 8; k++)
         dmux[k] = (out_valid && out_sel == 3'(k)) ? out_data : '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic out_is(input string tag, input logic v, input logic [2:0] s, input logic [W-1:0] d);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".sel"},   32'(out_sel),   32'(s));
      chk({tag, ".data"},  32'(out_data),  32'(d));
   endtask

   initial begin
      rst_n = 0; out_ready = 0; in_valid = 8'hFF;
      for (int k = 0; k < 8; k++) in_data[k*W +: W] = 16'h0100 + 16'(k);
      tick;
      out_is("rst0", 1'b0, 3'd0, 16'h0);
      chk("rst0.in_ready", 32'(in_ready), 32'h0);
      #2 rst_n = 1; in_valid = 8'b0000_1000; out_ready = 1;
      in_data[3*W +: W] = 16'hBEEF;
      #1 chk("single.in_ready", 32'(in_ready), 32'h08);
      tick;
      out_is("single", 1'b1, 3'd3, 16'hBEEF);
      in_data[3*W +: W] = 16'h0103;
      in_valid = 8'h80;
      tick;
      out_is("grant7", 1'b1, 3'd7, 16'h0107);
      in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick;
         out_is($sformatf("cont%0d", i), 1'b1, 3'(i % 8), 16'h0100 + 16'(i % 8));
      end
      for (int k = 0; k < 8; k++)
         chk($sformatf("dmux%0d", k), 32'(dmux[k]), (k == 0) ? 32'h0100 : 32'h0);
      for (int i = 1; i <= 5; i++) tick;
      out_is("pre_bp", 1'b1, 3'd5, 16'h0105);
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
         tick;
         out_is($sformatf("bp%0d", i), 1'b1, 3'd5, 16'h0105);
      end
      out_ready = 1;
      #1 chk("bp_rel.in_ready", 32'(in_ready), 32'h40);
      tick;
      out_is("bp_rel", 1'b1, 3'd6, 16'h0106);
      tick;
      out_is("to7", 1'b1, 3'd7, 16'h0107);
      in_valid = 8'b0100_0001;
      tick;
      out_is("wrap0", 1'b1, 3'd0, 16'h0100);
      tick;
      out_is("wrap6", 1'b1, 3'd6, 16'h0106);
      in_valid = 8'h00;
      #1 chk("idle.in_ready", 32'(in_ready), 32'h0);
      tick;
      out_is("drain", 1'b0, 3'd6, 16'h0106);
      in_valid = 8'h10;
      tick;
      out_is("ch4", 1'b1, 3'd4, 16'h0104);
      out_ready = 0;
      #2 rst_n = 0;
      #1 out_is("arst", 1'b0, 3'd0, 16'h0);
      chk("arst.in_ready", 32'(in_ready), 32'h0);
      tick;
      in_valid = 8'h84; out_ready = 1;
      #1 rst_n = 1;
      tick;
      out_is("post_rst", 1'b1, 3'd2, 16'h0102);
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
